// File: rtl/mp_word_comparator.sv
// Multi-precision magnitude comparator: walks two lockstep operand memories from the top word down.
// Optional: define MPCMP_SIGNED_EN to compare the top word (index L-1) as two's-complement signed.
module mp_word_comparator #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int RD_LATENCY = 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [DATA_WIDTH-1:0] rd_data_b,
  output logic                  done,
  output logic                  a_gt_b,
  output logic                  a_eq_b,
  output logic                  a_lt_b,
  output logic [ADDR_WIDTH-1:0] diff_index
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  localparam logic [ADDR_WIDTH:0] MAX_LEN = (ADDR_WIDTH+1)'(NUM_WORDS);

  state_t state_q, state_d;

  logic [ADDR_WIDTH:0]                     len_clamped;
  logic                                    accept;
  logic [RD_LATENCY-1:0]                   tag_vld_q;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]   tag_idx_q;
  logic [ADDR_WIDTH-1:0]                   tag_idx;
  logic                                    tag_live;
  logic                                    words_differ;
  logic                                    words_gt;
  logic                                    last_equal;

  assign len_clamped  = (len > MAX_LEN) ? MAX_LEN : len;
  assign accept       = (state_q == IDLE) && start;
  assign tag_idx      = tag_idx_q[RD_LATENCY-1];
  // Returned data is only trusted while a compare is actually in flight.
  assign tag_live     = tag_vld_q[RD_LATENCY-1] && ((state_q == ISSUE) || (state_q == DRAIN));
  assign words_differ = tag_live && (rd_data_a != rd_data_b);
  assign last_equal   = tag_live && (rd_data_a == rd_data_b) && (tag_idx == '0);

`ifdef MPCMP_SIGNED_EN
  logic [ADDR_WIDTH-1:0] top_idx_q;

  always_comb begin
    if (tag_idx == top_idx_q) words_gt = $signed(rd_data_a) > $signed(rd_data_b);
    else                      words_gt = rd_data_a > rd_data_b;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)      top_idx_q <= '0;
    else if (accept) top_idx_q <= ADDR_WIDTH'(len_clamped - 1'b1);
  end
`else
  assign words_gt = rd_data_a > rd_data_b;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // rd_en drops in the very cycle a difference is seen, so no further reads escape.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    rd_en   = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = (len_clamped == '0) ? DONE : ISSUE;
      end
      ISSUE: begin
        busy  = 1'b1;
        rd_en = !words_differ;
        if (words_differ)        state_d = DONE;
        else if (rd_addr == '0)  state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (words_differ || last_equal) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rd_addr    <= '0;
      a_gt_b     <= 1'b0;
      a_eq_b     <= 1'b0;
      a_lt_b     <= 1'b0;
      diff_index <= '0;
    end else if (accept) begin
      rd_addr    <= (len_clamped == '0) ? '0 : ADDR_WIDTH'(len_clamped - 1'b1);
      a_gt_b     <= 1'b0;
      a_lt_b     <= 1'b0;
      a_eq_b     <= (len_clamped == '0);
      diff_index <= '0;
    end else begin
      if (rd_en && (rd_addr != '0)) rd_addr <= rd_addr - 1'b1;
      if (words_differ) begin
        a_gt_b     <= words_gt;
        a_lt_b     <= !words_gt;
        diff_index <= tag_idx;
      end
      if (last_equal) a_eq_b <= 1'b1;
    end
  end

  // Tags ride alongside the memory latency; a decision flushes whatever is still in flight.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tag_vld_q <= '0;
      tag_idx_q <= '0;
    end else if (words_differ) begin
      tag_vld_q <= '0;
    end else begin
      tag_vld_q[0] <= rd_en;
      tag_idx_q[0] <= rd_addr;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

endmodule
